// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end for the serial adder: loads an operand pair plus
// bit length and emits it LSB-first as a vld/a/b/last stream gated by out_en.
module serial_operand_serializer #(
  parameter  int WIDTH = 8,
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [LW-1:0]    in_len,
  input  logic             out_en,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    eff_len;
  logic             accept;

  // Outputs depend only on registers and out_en, never on in_* data.
  assign vld      = (state_q == SHIFT) & out_en;
  assign a        = vld & sa_q[0];
  assign b        = vld & sb_q[0];
  assign last     = vld & (cnt_q == LW'(1));
  assign in_ready = (state_q == IDLE) | last;
  assign accept   = in_vld & in_ready;

  // Out-of-range lengths collapse to a full-width word.
  assign eff_len = ((in_len == '0) || (in_len > LW'(WIDTH))) ? LW'(WIDTH) : in_len;

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Also covers the final-bit cycle, so back-to-back words have no bubble.
      state_d = SHIFT;
      sa_d    = in_a;
      sb_d    = in_b;
      cnt_d   = eff_len;
    end else if (last) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (vld) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      cnt_d = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Self-checking bench: word-level model compared every cycle, plus directed
// literal expectations on the captured serial streams.
module tb_serial_operand_serializer;
  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic             clk = 0;
  logic             rst = 0;
  logic             in_vld = 0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [LW-1:0]    in_len = '0;
  logic             out_en = 1;
  logic             vld, a, b, last;

  serial_operand_serializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_len(in_len), .out_en(out_en),
    .vld(vld), .a(a), .b(b), .last(last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: current word, its length and index of the next bit.
  logic [WIDTH-1:0] m_a, m_b;
  int m_len = 0, m_idx = 0;
  bit m_busy = 0;

  function automatic int eff(input logic [LW-1:0] l);
    return (l == 0 || l > WIDTH) ? WIDTH : int'(l);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit e_vld, e_last, e_rdy;
    if (rst) begin
      m_busy = 0;
      m_idx  = 0;
    end else begin
      cyc++;
      e_vld  = m_busy && out_en;
      e_last = e_vld && (m_idx == m_len - 1);
      e_rdy  = !m_busy || e_last;
      if (e_vld) begin
        m_idx++;
        if (e_last) m_busy = 0;
      end
      if (in_vld && e_rdy) begin
        m_a = in_a; m_b = in_b; m_len = eff(in_len);
        m_idx = 0; m_busy = 1;
      end
    end
  end

  // Captured stream of emitted bit pairs.
  bit cap_a[$], cap_b[$], cap_l[$], cap_r[$];
  int cap_c[$];

  always @(negedge clk) begin
    bit e_vld, e_last, e_rdy, e_a, e_b;
    if (!rst) begin
      e_vld  = m_busy && out_en;
      e_last = e_vld && (m_idx == m_len - 1);
      e_rdy  = !m_busy || e_last;
      e_a    = e_vld ? m_a[m_idx] : 1'b0;
      e_b    = e_vld ? m_b[m_idx] : 1'b0;
      chk("vld", vld, e_vld);
      chk("last", last, e_last);
      chk("in_ready", in_ready, e_rdy);
      chk("a", a, e_a);
      chk("b", b, e_b);
      if (vld) begin
        cap_a.push_back(a); cap_b.push_back(b); cap_l.push_back(last);
        cap_r.push_back(in_ready); cap_c.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic clear_caps();
    cap_a.delete(); cap_b.delete(); cap_l.delete(); cap_r.delete(); cap_c.delete();
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [LW-1:0] lv);
    int n = 0;
    in_a = av; in_b = bv; in_len = lv; in_vld = 1;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_vld = 0;
  endtask

  task automatic wait_caps(input int n);
    int k = 0;
    while (cap_a.size() < n && k < 100) begin @(posedge clk); k++; end
    if (cap_a.size() < n) chk("stream_timeout", cap_a.size(), n);
    #1;
  endtask

  initial begin
    logic [4:0] sum;
    logic       cy;
    // Reset state
    rst = 1; #3;
    chk("rst_vld", vld, 0); chk("rst_last", last, 0);
    chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_ready", in_ready, 1);
    @(posedge clk); #2 rst = 0;
    @(posedge clk); #1;

    // Basic word, len 4
    clear_caps();
    send(8'h0B, 8'h05, 4'd4);
    wait_caps(4); repeat (3) @(posedge clk); #1;
    chk("t1_n", cap_a.size(), 4);
    chk("t1_a", pack(cap_a), 32'hB);
    chk("t1_b", pack(cap_b), 32'h5);
    chk("t1_last", pack(cap_l), 32'h8);
    chk("t1_ready", pack(cap_r), 32'h8);
    cy = 0; sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = cap_a[i] ^ cap_b[i] ^ cy;
      cy = (cap_a[i] & cap_b[i]) | (cy & (cap_a[i] ^ cap_b[i]));
    end
    sum[4] = cy;
    chk("t1_sum", sum, 5'b10000);

    // Back-to-back words
    clear_caps();
    send(8'h0B, 8'h05, 4'd4);
    send(8'hFF, 8'h01, 4'd8);
    wait_caps(12); repeat (3) @(posedge clk); #1;
    chk("t2_n", cap_a.size(), 12);
    chk("t2_a", pack(cap_a), 32'hFFB);
    chk("t2_b", pack(cap_b), 32'h015);
    chk("t2_last", pack(cap_l), 32'h808);
    chk("t2_gapless", cap_c[11] - cap_c[0], 11);

    // Stall after first bit
    clear_caps();
    send(8'h05, 8'h03, 4'd3);
    @(posedge clk); #1 out_en = 0;
    repeat (2) @(posedge clk);
    #1 out_en = 1;
    wait_caps(3); repeat (2) @(posedge clk); #1;
    chk("t3_n", cap_a.size(), 3);
    chk("t3_a", pack(cap_a), 32'h5);
    chk("t3_b", pack(cap_b), 32'h3);
    chk("t3_last", pack(cap_l), 32'h4);
    chk("t3_stall_gap", cap_c[1] - cap_c[0], 3);
    chk("t3_resume", cap_c[2] - cap_c[1], 1);

    // Length 1
    clear_caps();
    send(8'hFF, 8'hFF, 4'd1);
    wait_caps(1); repeat (2) @(posedge clk); #1;
    chk("t4_n", cap_a.size(), 1);
    chk("t4_abl", {cap_a[0], cap_b[0], cap_l[0]}, 3'b111);

    // Length 0 and length > WIDTH both mean full width
    clear_caps();
    send(8'hA5, 8'h3C, 4'd0);
    send(8'h5A, 8'hC3, 4'd12);
    wait_caps(16); repeat (3) @(posedge clk); #1;
    chk("t5_n", cap_a.size(), 16);
    chk("t5_a", pack(cap_a), 32'h5AA5);
    chk("t5_b", pack(cap_b), 32'hC33C);
    chk("t5_last", pack(cap_l), 32'h8080);

    // Async reset mid-word
    clear_caps();
    send(8'h2D, 8'h12, 4'd6);
    wait_caps(2);
    #2 rst = 1; #1;
    chk("t6_vld", vld, 0); chk("t6_last", last, 0);
    chk("t6_a", a, 0); chk("t6_b", b, 0);
    chk("t6_no_last", pack(cap_l), 0);
    @(posedge clk); #2 rst = 0; #1;
    chk("t6_ready", in_ready, 1);
    chk("t6_idle", vld, 0);
    repeat (3) @(posedge clk); #1;
    chk("t6_quiet", cap_a.size(), 2);

    // Inputs changed during SHIFT are ignored
    clear_caps();
    send(8'h96, 8'h69, 4'd8);
    in_a = 8'h00; in_b = 8'hFF; in_len = 4'd1;
    @(posedge clk); #1 in_a = 8'h5A;
    wait_caps(8); repeat (2) @(posedge clk); #1;
    chk("t7_n", cap_a.size(), 8);
    chk("t7_a", pack(cap_a), 32'h96);
    chk("t7_b", pack(cap_b), 32'h69);
    chk("t7_last", pack(cap_l), 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
